// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit.
// Contents: register-file geometry (XLEN, REG_ADDR_W, NUM_REGS),
// the wb_write_t record {rd, data}, and a one-hot decode helper.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_write_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bus bundle for the writeback unit.
// ALU result channel (alu_valid/alu_rd/alu_data -> alu_ready),
// load request channel (ld_req_valid/ld_req_rd -> ld_req_ready),
// load response channel (ld_rsp_valid/ld_rsp_data, no backpressure),
// register-file write port (RUWr/Rd/DataWr) and busy_mask scoreboard.
// master: the pipeline/bench side; slave: the writeback unit.
interface writeback_unit_if;
  import wb_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  alu_ready;

  logic                  ld_req_valid;
  logic [REG_ADDR_W-1:0] ld_req_rd;
  logic                  ld_req_ready;

  logic                  ld_rsp_valid;
  logic [XLEN-1:0]       ld_rsp_data;

  logic                  RUWr;
  logic [REG_ADDR_W-1:0] Rd;
  logic [XLEN-1:0]       DataWr;
  logic [NUM_REGS-1:0]   busy_mask;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_req_valid, ld_req_rd,
           ld_rsp_valid, ld_rsp_data,
    input  alu_ready, ld_req_ready, RUWr, Rd, DataWr, busy_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_req_valid, ld_req_rd,
           ld_rsp_valid, ld_rsp_data,
    output alu_ready, ld_req_ready, RUWr, Rd, DataWr, busy_mask
  );

endinterface

// File: rtl/wb_rd_fifo.sv
// In-order FIFO of pending load destination registers.
// Ports: clk, rst (sync, active-high), push/push_rd, pop, head_rd,
// full, empty, and every slot's entry plus valid bit so the parent
// can build the busy scoreboard. Caller never pushes when full nor
// pops when empty. Pointers carry one extra wrap bit so full and
// empty are distinguishable.
module wb_rd_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [REG_ADDR_W-1:0]            push_rd,
  input  logic                             pop,
  output logic [REG_ADDR_W-1:0]            head_rd,
  output logic                             full,
  output logic                             empty,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] entries,
  output logic [DEPTH-1:0]                 valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head_rd = entries[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        wr_ptr                    <= wr_ptr + 1'b1;
        valid[wr_ptr[PTR_W-1:0]] <= 1'b1;
      end
      if (pop) begin
        rd_ptr                    <= rd_ptr + 1'b1;
        valid[rd_ptr[PTR_W-1:0]] <= 1'b0;
      end
    end
  end

  // Slot payload needs no reset: it is only ever observed through valid.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr[PTR_W-1:0]] <= push_rd;
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates ALU results and in-order load responses
// onto a single registered register-file write port.
// Ports: clk, rst (sync, active-high), bus (writeback_unit_if.slave),
// and proto_err when WB_PROTO_CHECK_EN is defined (sticky flag for a
// response with nothing pending or a request while the queue is full).
// Load responses win over ALU results; an ALU result whose rd has a
// pending load is stalled so writes to one register stay ordered.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  writeback_unit_if.slave  bus
`ifdef WB_PROTO_CHECK_EN
  ,
  output logic             proto_err
`endif
);

  logic                                  full;
  logic                                  empty;
  logic [REG_ADDR_W-1:0]                 head_rd;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entries;
  logic [FIFO_DEPTH-1:0]                 valid;
  logic                                  push;
  logic                                  pop;
  logic                                  alu_accept;
  logic [NUM_REGS-1:0]                   busy;
  wb_write_t                             wr_sel;
  wb_write_t                             wr_p1;
  logic                                  we_p1;

  // A response arriving on an empty queue is dropped, even if a request
  // is entering in the same cycle; ready reflects the pre-edge state only.
  assign push = bus.ld_req_valid && !full  && !rst;
  assign pop  = bus.ld_rsp_valid && !empty && !rst;

  wb_rd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_rd (bus.ld_req_rd),
    .pop     (pop),
    .head_rd (head_rd),
    .full    (full),
    .empty   (empty),
    .entries (entries),
    .valid   (valid)
  );

  always_comb begin
    busy = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid[i]) busy = busy | rd_onehot(entries[i]);
    end
    busy[0] = 1'b0;
  end

  assign bus.busy_mask    = busy;
  assign bus.ld_req_ready = !full && !rst;
  assign bus.alu_ready    = !rst && !pop && !busy[bus.alu_rd];
  assign alu_accept       = bus.alu_valid && bus.alu_ready;

  always_comb begin
    wr_sel.rd   = bus.alu_rd;
    wr_sel.data = bus.alu_data;
    if (pop) begin
      wr_sel.rd   = head_rd;
      wr_sel.data = bus.ld_rsp_data;
    end
  end

  // Stage p1: registered write port; x0 writes are consumed with enable low.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_p1 <= 1'b0;
      wr_p1 <= '0;
    end else begin
      we_p1 <= (pop || alu_accept) && (wr_sel.rd != '0);
      if (pop || alu_accept) wr_p1 <= wr_sel;
    end
  end

  assign bus.RUWr   = we_p1;
  assign bus.Rd     = wr_p1.rd;
  assign bus.DataWr = wr_p1.data;

`ifdef WB_PROTO_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) proto_err <= 1'b0;
    else if ((bus.ld_rsp_valid && empty) || (bus.ld_req_valid && full))
      proto_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: a table of single-cycle ALU
// vectors, directed multi-cycle sequences, then randomized traffic
// checked against a queue-based reference model.
module tb_writeback_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  writeback_unit_if bus ();
`ifdef WB_PROTO_CHECK_EN
  logic proto_err;
`endif

  writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WB_PROTO_CHECK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic [4:0]  erd;
    logic [31:0] edata;
  } vec_t;

  vec_t       tbl [6];
  logic [4:0] q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid    = 1'b0;
    bus.alu_rd       = '0;
    bus.alu_data     = '0;
    bus.ld_req_valid = 1'b0;
    bus.ld_req_rd    = '0;
    bus.ld_rsp_valid = 1'b0;
    bus.ld_rsp_data  = '0;
  endtask

  task automatic chk_wr(input string nm, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({nm, ".RUWr"}, {31'd0, bus.RUWr}, {31'd0, we});
    chk({nm, ".Rd"}, {27'd0, bus.Rd}, {27'd0, rd});
    chk({nm, ".DataWr"}, bus.DataWr, d);
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) if (q[i] != 5'd0) m[q[i]] = 1'b1;
    return m;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] eb;
    logic        ear, elr, rsp_go, wr_go;
    logic [4:0]  wrd, last_rd;
    logic [31:0] wdata, last_data;
    int          pre;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    tbl[1] = '{1'b0, 5'd9,  32'h00001234, 1'b0, 5'd5,  32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
    tbl[3] = '{1'b1, 5'd0,  32'h00000055, 1'b0, 5'd0,  32'h00000055};
    tbl[4] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd1,  32'h00000001};
    tbl[5] = '{1'b0, 5'd1,  32'h00000000, 1'b0, 5'd1,  32'h00000001};

    // Reset state and no acceptance while rst is high
    rst = 1'b1;
    idle();
    bus.alu_valid    = 1'b1;
    bus.alu_rd       = 5'd6;
    bus.ld_req_valid = 1'b1;
    bus.ld_req_rd    = 5'd6;
    tick();
    tick();
    chk("rst.alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    chk("rst.ld_req_ready", {31'd0, bus.ld_req_ready}, 32'd0);
    rst = 1'b0;
    idle();
    #1;
    chk_wr("rst", 1'b0, 5'd0, 32'd0);
    chk("rst.busy", bus.busy_mask, 32'd0);
    chk("rst.ld_req_ready_after", {31'd0, bus.ld_req_ready}, 32'd1);
`ifdef WB_PROTO_CHECK_EN
    chk("rst.proto_err", {31'd0, proto_err}, 32'd0);
`endif

    // Table: ALU writes with an empty load queue
    for (int i = 0; i < 6; i++) begin
      bus.alu_valid = tbl[i].v;
      bus.alu_rd    = tbl[i].rd;
      bus.alu_data  = tbl[i].data;
      tick();
      idle();
      chk_wr($sformatf("tbl%0d", i), tbl[i].we, tbl[i].erd, tbl[i].edata);
    end

    // ALU write to a register with a pending load stalls until the load returns
    do_reset();
    bus.ld_req_valid = 1'b1;
    bus.ld_req_rd    = 5'd7;
    tick();
    idle();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    bus.alu_data  = 32'h77;
    #1;
    chk("waw.busy", bus.busy_mask, 32'h80);
    chk("waw.alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    tick();
    chk("waw.stall_RUWr", {31'd0, bus.RUWr}, 32'd0);
    bus.ld_rsp_valid = 1'b1;
    bus.ld_rsp_data  = 32'h11;
    tick();
    bus.ld_rsp_valid = 1'b0;
    chk_wr("waw.load", 1'b1, 5'd7, 32'h11);
    #1;
    chk("waw.busy_clear", bus.busy_mask, 32'd0);
    chk("waw.alu_ready_after", {31'd0, bus.alu_ready}, 32'd1);
    tick();
    idle();
    chk_wr("waw.alu", 1'b1, 5'd7, 32'h77);

    // Load response has priority over a same-cycle ALU result
    bus.ld_req_valid = 1'b1;
    bus.ld_req_rd    = 5'd3;
    tick();
    idle();
    bus.ld_rsp_valid = 1'b1;
    bus.ld_rsp_data  = 32'hAA;
    bus.alu_valid    = 1'b1;
    bus.alu_rd       = 5'd4;
    bus.alu_data     = 32'h44;
    #1;
    chk("prio.alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    tick();
    bus.ld_rsp_valid = 1'b0;
    chk_wr("prio.load", 1'b1, 5'd3, 32'hAA);
    tick();
    idle();
    chk_wr("prio.alu", 1'b1, 5'd4, 32'h44);

    // Fill the queue, overflow attempt, drain in order
    for (int i = 1; i <= 4; i++) begin
      bus.ld_req_valid = 1'b1;
      bus.ld_req_rd    = 5'(i);
      #1;
      chk($sformatf("full.ready%0d", i), {31'd0, bus.ld_req_ready}, 32'd1);
      tick();
    end
    idle();
    #1;
    chk("full.ready_low", {31'd0, bus.ld_req_ready}, 32'd0);
    chk("full.busy", bus.busy_mask, 32'h1E);
    bus.ld_req_valid = 1'b1;
    bus.ld_req_rd    = 5'd9;
    tick();
    idle();
    chk("full.dropped", bus.busy_mask, 32'h1E);
`ifdef WB_PROTO_CHECK_EN
    chk("full.proto_err", {31'd0, proto_err}, 32'd1);
`endif
    for (int i = 1; i <= 4; i++) begin
      bus.ld_rsp_valid = 1'b1;
      bus.ld_rsp_data  = 32'h100 + 32'(i);
      tick();
      chk_wr($sformatf("drain%0d", i), 1'b1, 5'(i), 32'h100 + 32'(i));
    end
    idle();
    #1;
    chk("drain.busy", bus.busy_mask, 32'd0);
    chk("drain.ready", {31'd0, bus.ld_req_ready}, 32'd1);

    // Load to x0 pops silently; empty-queue response is ignored
    do_reset();
    bus.ld_req_valid = 1'b1;
    bus.ld_req_rd    = 5'd0;
    tick();
    idle();
    #1;
    chk("x0.busy", bus.busy_mask, 32'd0);
    bus.ld_rsp_valid = 1'b1;
    bus.ld_rsp_data  = 32'h99;
    tick();
    idle();
    chk("x0.RUWr", {31'd0, bus.RUWr}, 32'd0);
    bus.ld_req_valid = 1'b1;
    bus.ld_req_rd    = 5'd8;
    tick();
    idle();
    bus.ld_rsp_valid = 1'b1;
    bus.ld_rsp_data  = 32'h88;
    tick();
    idle();
    chk_wr("x0.popped", 1'b1, 5'd8, 32'h88);
    bus.ld_rsp_valid = 1'b1;
    bus.ld_rsp_data  = 32'h55;
    bus.ld_req_valid = 1'b1;
    bus.ld_req_rd    = 5'd12;
    tick();
    idle();
    chk("empty.RUWr", {31'd0, bus.RUWr}, 32'd0);
    #1;
    chk("empty.push_kept", bus.busy_mask, 32'h1000);
`ifdef WB_PROTO_CHECK_EN
    chk("empty.proto_err", {31'd0, proto_err}, 32'd1);
`endif
    bus.ld_rsp_valid = 1'b1;
    bus.ld_rsp_data  = 32'h66;
    tick();
    idle();
    chk_wr("empty.next", 1'b1, 5'd12, 32'h66);

    // Reset mid-operation discards pending loads
    bus.ld_req_valid = 1'b1;
    bus.ld_req_rd    = 5'd2;
    tick();
    bus.ld_req_rd    = 5'd3;
    tick();
    idle();
    #1;
    chk("mid.busy_before", bus.busy_mask, 32'h0C);
    rst              = 1'b1;
    bus.alu_valid    = 1'b1;
    bus.alu_rd       = 5'd10;
    bus.ld_req_valid = 1'b1;
    bus.ld_req_rd    = 5'd11;
    #1;
    chk("mid.alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    chk("mid.ld_req_ready", {31'd0, bus.ld_req_ready}, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    chk_wr("mid", 1'b0, 5'd0, 32'd0);
    #1;
    chk("mid.busy", bus.busy_mask, 32'd0);
    chk("mid.ready", {31'd0, bus.ld_req_ready}, 32'd1);
`ifdef WB_PROTO_CHECK_EN
    chk("mid.proto_err", {31'd0, proto_err}, 32'd0);
`endif
    bus.ld_rsp_valid = 1'b1;
    bus.ld_rsp_data  = 32'h33;
    tick();
    idle();
    chk("mid.rsp_ignored", {31'd0, bus.RUWr}, 32'd0);

    // Randomized traffic against a queue model
    do_reset();
    q.delete();
    last_rd   = '0;
    last_data = '0;
    for (int c = 0; c < 500; c++) begin
      bus.alu_valid    = ($urandom_range(0, 3) != 0);
      bus.alu_rd       = 5'($urandom_range(0, 7));
      bus.alu_data     = $urandom;
      bus.ld_req_valid = ($urandom_range(0, 2) == 0);
      bus.ld_req_rd    = 5'($urandom_range(0, 7));
      bus.ld_rsp_valid = ($urandom_range(0, 2) == 0);
      bus.ld_rsp_data  = $urandom;
      #1;
      pre    = q.size();
      eb     = model_busy();
      rsp_go = bus.ld_rsp_valid && (pre > 0);
      ear    = !rsp_go && !eb[bus.alu_rd];
      elr    = (pre < DEPTH);
      chk("rnd.busy", bus.busy_mask, eb);
      chk("rnd.alu_ready", {31'd0, bus.alu_ready}, {31'd0, ear});
      chk("rnd.ld_req_ready", {31'd0, bus.ld_req_ready}, {31'd0, elr});
      wr_go = 1'b0;
      wrd   = '0;
      wdata = '0;
      if (rsp_go) begin
        wr_go = 1'b1;
        wrd   = q.pop_front();
        wdata = bus.ld_rsp_data;
      end else if (bus.alu_valid && ear) begin
        wr_go = 1'b1;
        wrd   = bus.alu_rd;
        wdata = bus.alu_data;
      end
      if (bus.ld_req_valid && elr) q.push_back(bus.ld_req_rd);
      if (wr_go) begin
        last_rd   = wrd;
        last_data = wdata;
      end
      tick();
      chk_wr("rnd", wr_go && (wrd != 5'd0), last_rd, last_data);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
